// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared widths and fetch entry type for the 16-bit RISC pipeline
//
// Purpose: constants and the {pc, instr} entry type shared by the fetch,
//          fetch_queue and decode stages.
// Ports:   none (package).
package rv_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    // Sequential step between instruction addresses (16-bit instructions).
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(2);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - DEPTH-entry fetch entry register array, one write port, one async read port
//
// Purpose: entry storage for fetch_queue. No reset; the queue's occupancy
//          counter decides which entries are meaningful.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   entry to write
//   raddr  in   read index
//   rdata  out  entry at raddr (combinational)
module fq_storage
    import rv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  fetch_entry_t      wdata,
    input  logic [PTR_W-1:0]  raddr,
    output fetch_entry_t      rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch-to-decode instruction queue with flush and pc+2
//
// Purpose: buffers up to DEPTH {pc, instr} pairs between fetch and decode,
//          absorbs decode stalls and discards everything on a redirect flush.
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   in_valid      in   fetch presents a pair
//   in_ready      out  queue accepts the pair this cycle (not full)
//   in_pc         in   address of the fetched instruction
//   in_instr      in   fetched instruction word
//   flush         in   redirect; empties the queue, overrides push/pop
//   out_valid     out  head entry valid
//   out_ready     in   decode consumes the head
//   out_pc        out  head address (0 when empty)
//   out_instr     out  head instruction (0 when empty)
//   out_pc_plus2  out  out_pc + 2, wrapping
//   count         out  occupancy
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = rv_pkg::PC_W,
    parameter int INSTR_W = rv_pkg::INSTR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [PC_W-1:0]          out_pc_plus2,
    output logic [$clog2(DEPTH):0]   count
);

    import rv_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occ;
    logic             push;
    logic             pop;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    // Readiness depends on occupancy only: a full queue never takes a pair
    // even when decode pops in the same cycle.
    assign in_ready  = (occ != FULL);
    assign out_valid = (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
        end
    end

    assign wr_entry.pc    = in_pc;
    assign wr_entry.instr = in_instr;

    fq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Storage is unreset; mask it while empty so stale entries never show.
    assign out_pc       = out_valid ? head.pc    : '0;
    assign out_instr    = out_valid ? head.instr : '0;
    assign out_pc_plus2 = out_pc + PC_STEP;
    assign count        = occ;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue model
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_pc = '0;
    logic [15:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic [15:0] out_pc_plus2;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .PC_W(16), .INSTR_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_pc_plus2 (out_pc_plus2),
        .count        (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain FIFO of {pc, instr}.
    logic [31:0] mq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [15:0] epc;
        logic [15:0] ein;
        logic [15:0] e2;
        epc = (mq.size() != 0) ? mq[0][31:16] : 16'h0000;
        ein = (mq.size() != 0) ? mq[0][15:0]  : 16'h0000;
        e2  = epc + 16'd2;
        check("count",        32'(count),        32'(mq.size()));
        check("out_valid",    32'(out_valid),    32'(mq.size() != 0));
        check("in_ready",     32'(in_ready),     32'(mq.size() != DEPTH));
        check("out_pc",       32'(out_pc),       32'(epc));
        check("out_instr",    32'(out_instr),    32'(ein));
        check("out_pc_plus2", 32'(out_pc_plus2), 32'(e2));
    endtask

    // One clock: decide push/pop from pre-edge inputs, update model, compare.
    task automatic step(output bit pushed);
        bit do_push;
        bit do_pop;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = out_ready && (mq.size() > 0);
        @(posedge clk);
        pushed = 1'b0;
        if (flush) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({in_pc, in_instr});
                pushed = 1'b1;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] ins, input logic rdy);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = rdy;
    endtask

    bit          pushed;
    logic [15:0] next_pc;

    initial begin
        // Reset held with in_valid asserted: nothing may enter.
        drive(1'b1, 16'h0000, 16'h1234, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        check("rst_plus2", 32'(out_pc_plus2), 32'h0002);

        // Release and take the first pair on the first edge.
        rst = 1'b1;
        step(pushed);
        check("first_push_instr", 32'(out_instr), 32'h1234);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        step(pushed);

        // Fill to full under stall.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 16'(2 * i), 16'(16'hA000 + i), 1'b0);
            step(pushed);
        end
        drive(1'b1, 16'h0008, 16'hA004, 1'b0);
        step(pushed);
        check("full_count", 32'(count), 32'd4);
        check("full_head", 32'(out_pc), 32'h0000);

        // Full with concurrent pop: pop only, then the held pair goes in.
        out_ready = 1'b1;
        step(pushed);
        check("full_pop_count", 32'(count), 32'd3);
        out_ready = 1'b0;
        step(pushed);
        check("retry_accepted", 32'(pushed), 32'd1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        repeat (DEPTH) step(pushed);

        // Streaming through the pointer wrap: steady occupancy of one.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'(16'h0010 + 2 * i), 16'($urandom), 1'b1);
            step(pushed);
            check("stream_count", 32'(count), 32'd1);
            check("stream_pc", 32'(out_pc), 32'(16'h0010 + 2 * i));
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        step(pushed);

        // Flush priority over concurrent push and pop.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(16'h0040 + 2 * i), 16'($urandom), 1'b0);
            step(pushed);
        end
        drive(1'b1, 16'h0100, 16'hBEEF, 1'b1);
        flush = 1'b1;
        step(pushed);
        flush = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        repeat (2) step(pushed);

        // pc+2 wrap at the top of the address space.
        drive(1'b1, 16'hFFFE, 16'h5555, 1'b0);
        step(pushed);
        check("plus2_wrap", 32'(out_pc_plus2), 32'h0000);
        drive(1'b1, 16'h0000, 16'h6666, 1'b0);
        step(pushed);
        in_valid = 1'b0;

        // Asynchronous reset mid-cycle with two entries buffered.
        #3;
        rst = 1'b0;
        #1;
        mq.delete();
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_outputs();

        // Randomized traffic with fetch holding each pair until accepted.
        next_pc  = 16'h0200;
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || pushed) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_pc    = next_pc;
                in_instr = 16'($urandom);
                next_pc  = next_pc + 16'd2;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            step(pushed);
            if (flush) pushed = 1'b1;
            flush = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue sitting between the program-counter/instruction-memory fetch stage and the decode stage of the pipelined 16-bit RISC core. It accepts {pc, instruction} pairs from fetch over a valid/ready handshake, buffers up to DEPTH entries in order, and presents them to decode along with the sequential successor address pc+2. A flush input discards all buffered entries on a branch/jump redirect. It is the consumer of the addresses the PC register produces, and it absorbs decode stalls so fetch does not need to stop on every stall cycle.

## Interface
- DEPTH, 4, number of queue entries; power of two, 2..16
- PC_W, 16, address width
- INSTR_W, 16, instruction width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents a valid pair
- in_ready  out  1  queue can accept the pair this cycle
- in_pc  in  PC_W  address of the fetched instruction
- in_instr  in  INSTR_W  fetched instruction word
- flush  in  1  redirect; discard all entries
- out_valid  out  1  head entry is valid
- out_ready  in  1  decode consumes the head this cycle
- out_pc  out  PC_W  head entry address
- out_instr  out  INSTR_W  head entry instruction
- out_pc_plus2  out  PC_W  out_pc + 2, modulo 2^PC_W
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer with write pointer, read pointer, and occupancy counter. Pointers wrap from DEPTH-1 to 0.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count != DEPTH). This depends only on occupancy, so there is no pass-through on a full queue even if a pop happens in the same cycle.
- out_valid = (count != 0). out_pc and out_instr show the head entry and are stable while out_valid && !out_ready.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any occupancy from 1 to DEPTH-1, and at DEPTH only if in_ready allowed the push, which it does not.
- Push into an empty queue: the entry is visible at the output after the next edge. Decode never sees an entry combinationally from the input.
- flush has priority over everything. On the edge where flush=1, the pointers and count go to 0, and any concurrent push or pop is dropped. The cycle after a flush, out_valid=0 and in_ready=1.
- out_pc_plus2 is a combinational 16-bit add of out_pc and 2 with wrap. 0xFFFE gives 0x0000; there is no carry out.
- The queue does not check pc continuity. Addresses pass through unchanged.

## Timing
- Reset (rst=0, asynchronous) sets pointers and count to 0 immediately. Outputs during and after reset: out_valid=0, in_ready=1, count=0, out_pc=0, out_instr=0, out_pc_plus2=2.
- Release of rst is synchronous to clk. The first push can happen on the first rising edge with rst=1.
- Reset asserted mid-operation discards all entries with no drain.
- Latency from input to output is 1 cycle.
- Throughput is 1 entry/cycle sustained when 0 < count < DEPTH.
- Entry storage needs no reset. out_pc and out_instr are forced to 0 while count=0, so stale data is never driven.
- Handshake rules:
  - in_valid and in_* must be held until accepted. The queue does not sample them otherwise.
  - out_ready may change freely.
  - flush is a single-cycle pulse per redirect. If it is held, the queue stays empty.

## Structure
- Shared package rv_pkg holds:
  - PC_W=16 and INSTR_W=16
  - PC_STEP=2
  - the typedef fetch_entry_t = {pc, instr}, used by the fetch, queue and decode stages
- Sub-module fq_storage: a DEPTH x fetch_entry_t register array with one write port and one asynchronous read port, and no reset.
- fetch_queue itself holds the pointers, counter, handshake and flush logic, and the pc+2 adder.

## Test plan
- Reset and empty:
  - Stimulus: hold rst=0 with in_valid=1.
  - Required: count=0, out_valid=0, in_ready=1, out_pc=0, out_pc_plus2=0x0002.
  - Required after release: one push of pc=0x0000, instr=0x1234 gives out_valid=1 and out_instr=0x1234 one edge later.
- Fill to full under stall:
  - Stimulus: out_ready=0, push pc 0x0000/0x0002/0x0004/0x0006.
  - Required: count=4, in_ready=0. A fifth pair with pc=0x0008 is not accepted and the head stays at 0x0000.
- Full with concurrent pop:
  - Stimulus: full queue, in_valid=1, out_ready=1.
  - Required: the pop happens, the push does not, and count=3. On the next cycle the push of 0x0008 is accepted.
- Streaming and wrap:
  - Stimulus: 20 back-to-back pushes from pc=0x0010 step 2, with out_ready=1.
  - Required: pops come out in order with no bubbles after the first, the pointers wrap at least 4 times, and count stays at 1.
- Flush priority:
  - Stimulus: count=3, then one cycle with flush=1, in_valid=1 (pc=0x0100) and out_ready=1.
  - Required: the next cycle shows count=0 and out_valid=0. 0x0100 is never output.
- pc+2 wrap and async reset:
  - Stimulus: push pc=0xFFFE.
  - Required: out_pc_plus2=0x0000.
  - Stimulus: then assert rst mid-cycle with count=2.
  - Required: out_valid drops before the next edge.
